// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one sum/carry cell reused for every bit position, LSB first.
// Accepts start in IDLE, runs WIDTH steps, then pulses done for one cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit position added per cycle, busy=1
// DONE  | result registered, done=1 for exactly one cycle
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             p;
  logic             bit_s;
  logic             c_nxt;
  logic [WIDTH-1:0] s_nxt;

  // two half-adder cells plus the carry OR
  assign p     = a_sh[0] ^ b_sh[0];
  assign bit_s = p ^ c;
  assign c_nxt = (a_sh[0] & b_sh[0]) | (p & c);
  assign s_nxt = {bit_s, s_sh[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_nxt;
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          // last bit goes straight into the result so it lands whole
          if (cnt == LAST_STEP) begin
            sum_out   <= s_nxt;
            carry_out <= c_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: cycle model at WIDTH=8 plus
// directed vectors, and an exhaustive sweep on a WIDTH=2 instance.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum_out;

  logic         start2 = 1'b0;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic         busy2, done2, carry2;
  logic [1:0]   sum2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .sum_out(sum2), .carry_out(carry2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: cycles since acceptance; result is plain a+b, visible W cycles later.
  int           m_t = -1;
  logic [W:0]   m_pending = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_carry = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_t     <= -1;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t       <= 0;
        m_pending <= {1'b0, a_in} + {1'b0, b_in};
      end
    end else if (m_t == W - 1) begin
      {m_carry, m_sum} <= m_pending;
      m_t <= W;
    end else if (m_t == W) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clock) begin
    chk("busy", 32'(busy), 32'(m_t >= 0 && m_t < W));
    chk("done", 32'(done), 32'(m_t == W));
    chk("sum_out", 32'(sum_out), 32'(m_sum));
    chk("carry_out", 32'(carry_out), 32'(m_carry));
  end

  task automatic wait_done(input string nm, output int k);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!done) chk({nm, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_s, input logic exp_c);
    int k;
    @(negedge clock);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a_in = ~a; b_in = ~b;
    wait_done(nm, k);
    chk({nm, "_latency"}, 32'(k), 32'(W));
    chk({nm, "_sum"}, 32'(sum_out), 32'(exp_s));
    chk({nm, "_carry"}, 32'(carry_out), 32'(exp_c));
    @(negedge clock);
  endtask

  initial begin
    int k, pulses, t_first, t_second;
    start = 1'b1; a_in = 8'hA5; b_in = 8'h3C;
    #2;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_sum", 32'(sum_out), 32'd0);
    chk("t1_carry", 32'(carry_out), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_op("t2", 8'h35, 8'h4A, 8'h7F, 1'b0);
    run_op("t3a", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("t3b", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("alt", 8'hAA, 8'h55, 8'hFF, 1'b0);

    // T4: second start while running is ignored
    @(negedge clock);
    a_in = 8'h35; b_in = 8'h4A; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    repeat (14) begin
      if (done) pulses++;
      @(negedge clock);
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_sum", 32'(sum_out), 32'h7F);

    // T5: start held high gives back-to-back ops
    a_in = 8'h35; b_in = 8'h4A; start = 1'b1;
    @(negedge clock);
    a_in = 8'h10; b_in = 8'h20;
    wait_done("t5a", k);
    t_first = cyc;
    chk("t5_first_sum", 32'(sum_out), 32'h7F);
    repeat (9) @(negedge clock);
    chk("t5_hold_sum", 32'(sum_out), 32'h7F);
    chk("t5_hold_done", 32'(done), 32'd0);
    @(negedge clock);
    start = 1'b0;
    wait_done("t5b", k);
    t_second = cyc;
    chk("t5_spacing", 32'(t_second - t_first), 32'd10);
    chk("t5_second_sum", 32'(sum_out), 32'h30);
    repeat (2) @(negedge clock);

    // T6: reset mid-operation
    a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_sum", 32'(sum_out), 32'd0);
    chk("t6_carry", 32'(carry_out), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) pulses++;
    end
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("t6_no_done", 32'(pulses), 32'd0);
    run_op("t6_after", 8'h80, 8'h80, 8'h00, 1'b1);

    // exhaustive sweep on the 2-bit instance
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clock);
        a2 = 2'(a); b2 = 2'(b); start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0; a2 = ~2'(a); b2 = ~2'(b);
        k = 0;
        while (!done2 && k < 20) begin
          @(negedge clock);
          k++;
        end
        chk("w2_latency", 32'(k), 32'd2);
        chk("w2_sum", 32'(sum2), 32'((a + b) % 4));
        chk("w2_carry", 32'(carry2), 32'((a + b) / 4));
        @(negedge clock);
      end
    end

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
